// File: rtl/text_buffer.sv
// Character-cell frame store with cursor, CR/LF/BS/FF handling and ring scroll.
// Optional cursor blink enabled by defining TEXT_BUFFER_CURSOR_BLINK_EN.
module text_buffer #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       Clk,
    input  logic       rst,
    input  logic [7:0] in_ascii,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] pix_row,
    input  logic [9:0] pix_col,
    input  logic       frame_tick,
    output logic [7:0] glyph_code,
    output logic [3:0] glyph_line,
    output logic [2:0] glyph_col,
    output logic       cursor_on,
    output logic [6:0] cur_x,
    output logic [4:0] cur_y
);
    localparam int N  = COLS * ROWS;
    localparam int AW = $clog2(N);
    localparam logic [1:0] S_CLEAR_ALL  = 2'd0;
    localparam logic [1:0] S_IDLE       = 2'd1;
    localparam logic [1:0] S_CLEAR_LINE = 2'd2;
    localparam logic [6:0] XMAX = 7'(COLS - 1);
    localparam logic [4:0] YMAX = 5'(ROWS - 1);

    logic [7:0]    mem_q [N];
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] base_q, base_d;
    logic [6:0]    x_q, x_d;
    logic [4:0]    y_q, y_d;
    logic [4:0]    top_q, top_d;
    logic          ready_q;
    logic [7:0]    glyph_q;
    logic [3:0]    line_q;
    logic [2:0]    col_q;

    logic          acc, we, nl;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic [4:0]    wline;
    logic [6:0]    rd_x;
    logic [4:0]    rd_y;
    logic          in_rng;
    logic [AW-1:0] raddr;

    // Screen line to physical line via compare-and-subtract.
    function automatic logic [4:0] phys(input logic [4:0] l, input logic [4:0] t);
        logic [5:0] s;
        s = {1'b0, l} + {1'b0, t};
        if (s >= 6'(ROWS)) s = s - 6'(ROWS);
        return s[4:0];
    endfunction

    function automatic logic [AW-1:0] addr(input logic [4:0] l, input logic [6:0] x);
        return AW'(l) * AW'(COLS) + AW'(x);
    endfunction

    assign acc   = in_valid && ready_q;
    assign wline = phys(y_q, top_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        x_d     = x_q;
        y_d     = y_q;
        top_d   = top_q;
        we      = 1'b0;
        waddr   = cnt_q;
        wdata   = 8'h20;
        nl      = 1'b0;
        case (state_q)
            S_CLEAR_ALL: begin
                we = 1'b1;
                if (cnt_q == AW'(N - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_CLEAR_LINE: begin
                we    = 1'b1;
                waddr = base_q + cnt_q;
                if (cnt_q == AW'(COLS - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                if (acc) begin
                    unique case (1'b1)
                        (in_ascii >= 8'h20 && in_ascii <= 8'h7E): begin
                            we    = 1'b1;
                            waddr = addr(wline, x_q);
                            wdata = in_ascii;
                            if (x_q == XMAX) begin
                                x_d = '0;
                                nl  = 1'b1;
                            end else begin
                                x_d = x_q + 7'd1;
                            end
                        end
                        (in_ascii == 8'h0D): x_d = '0;
                        (in_ascii == 8'h0A): nl = 1'b1;
                        (in_ascii == 8'h08): begin
                            if (x_q != '0) begin
                                x_d   = x_q - 7'd1;
                                we    = 1'b1;
                                waddr = addr(wline, x_q - 7'd1);
                            end
                        end
                        (in_ascii == 8'h0C): begin
                            x_d     = '0;
                            y_d     = '0;
                            top_d   = '0;
                            cnt_d   = '0;
                            state_d = S_CLEAR_ALL;
                        end
                        default: ;
                    endcase
                    if (nl) begin
                        if (y_q != YMAX) begin
                            y_d = y_q + 5'd1;
                        end else begin
                            // Old top line becomes the new bottom line.
                            top_d   = (top_q == YMAX) ? 5'd0 : top_q + 5'd1;
                            base_d  = addr(top_q, 7'd0);
                            cnt_d   = '0;
                            state_d = S_CLEAR_LINE;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_CLEAR_ALL;
            cnt_q   <= '0;
            base_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            top_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            x_q     <= x_d;
            y_q     <= y_d;
            top_q   <= top_d;
            ready_q <= (state_d == S_IDLE);
        end
    end

    always_ff @(posedge Clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rd_x   = pix_col[9:3];
    assign rd_y   = pix_row[8:4];
    assign in_rng = (pix_col < 10'(COLS * 8)) && (pix_row < 9'(ROWS * 16));
    assign raddr  = addr(phys(rd_y, top_q), rd_x);

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            glyph_q <= 8'h20;
            line_q  <= '0;
            col_q   <= '0;
        end else begin
            glyph_q <= in_rng ? mem_q[raddr] : 8'h20;
            line_q  <= pix_row[3:0];
            col_q   <= pix_col[2:0];
        end
    end

`ifdef TEXT_BUFFER_CURSOR_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    logic [FW-1:0] fcnt_q;
    logic          phase_q;
    logic          curs_q;

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
            curs_q  <= 1'b0;
        end else begin
            if (acc) begin
                fcnt_q  <= '0;
                phase_q <= 1'b1;
            end else if (frame_tick) begin
                if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                    fcnt_q  <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    fcnt_q <= fcnt_q + FW'(1);
                end
            end
            curs_q <= in_rng && (rd_x == x_q) && (rd_y == y_q) && phase_q;
        end
    end

    assign cursor_on = curs_q;
`else
    logic unused_blink;
    assign unused_blink = frame_tick ^ (BLINK_FRAMES == 0);
    assign cursor_on    = 1'b0;
`endif

    assign in_ready   = ready_q;
    assign glyph_code = glyph_q;
    assign glyph_line = line_q;
    assign glyph_col  = col_q;
    assign cur_x      = x_q;
    assign cur_y      = y_q;
endmodule

// File: tb/tb_text_buffer.sv
// Directed self-checking bench for text_buffer.
module tb_text_buffer;
    logic       Clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_ascii = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] pix_row = '0;
    logic [9:0] pix_col = '0;
    logic       frame_tick = 1'b0;
    logic [7:0] glyph_code;
    logic [3:0] glyph_line;
    logic [2:0] glyph_col;
    logic       cursor_on;
    logic [6:0] cur_x;
    logic [4:0] cur_y;

    int checks = 0;
    int errors = 0;
    int n;

    text_buffer #(.COLS(80), .ROWS(30), .BLINK_FRAMES(2)) dut (
        .Clk(Clk), .rst(rst),
        .in_ascii(in_ascii), .in_valid(in_valid), .in_ready(in_ready),
        .pix_row(pix_row), .pix_col(pix_col), .frame_tick(frame_tick),
        .glyph_code(glyph_code), .glyph_line(glyph_line),
        .glyph_col(glyph_col), .cursor_on(cursor_on),
        .cur_x(cur_x), .cur_y(cur_y)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!in_ready && cnt < 5000) begin
            tick();
            cnt++;
        end
    endtask

    task automatic send(input logic [7:0] c);
        int w;
        in_ascii = c;
        in_valid = 1'b1;
        wait_ready(w);
        if (!in_ready) chk("send_timeout", 16'(in_ready), 16'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic rd(input logic [8:0] r, input logic [9:0] c);
        pix_row = r;
        pix_col = c;
        tick();
    endtask

    task automatic pulse_frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_ready", 16'(in_ready), 16'd0);
        chk("rst_glyph", 16'(glyph_code), 16'h20);
        chk("rst_line", 16'(glyph_line), 16'd0);
        chk("rst_col", 16'(glyph_col), 16'd0);
        chk("rst_cursor", 16'(cursor_on), 16'd0);
        chk("rst_x", 16'(cur_x), 16'd0);
        chk("rst_y", 16'(cur_y), 16'd0);

        in_valid = 1'b1;
        in_ascii = 8'h00;
        rst = 1'b1;
        wait_ready(n);
        chk("clr_all_cycles", 16'(n), 16'd2400);
        in_valid = 1'b0;
        chk("init_x", 16'(cur_x), 16'd0);
        chk("init_y", 16'(cur_y), 16'd0);
        rd(9'd0, 10'd0);
        chk("blank_first", 16'(glyph_code), 16'h20);
        rd(9'd479, 10'd639);
        chk("blank_last", 16'(glyph_code), 16'h20);
        rd(9'd243, 10'd325);
        chk("blank_mid", 16'(glyph_code), 16'h20);

        in_valid = 1'b1;
        in_ascii = 8'h41;
        tick();
        chk("ready_b2b", 16'(in_ready), 16'd1);
        in_ascii = 8'h42;
        tick();
        in_valid = 1'b0;
        chk("ab_x", 16'(cur_x), 16'd2);
        rd(9'd0, 10'd0);
        chk("cell_00_A", 16'(glyph_code), 16'h41);
        rd(9'd5, 10'd11);
        chk("cell_10_B", 16'(glyph_code), 16'h42);
        chk("glyph_line", 16'(glyph_line), 16'd5);
        chk("glyph_col", 16'(glyph_col), 16'd3);

        send(8'h0D);
        chk("cr_x", 16'(cur_x), 16'd0);
        send(8'h58);
        chk("x_after_X", 16'(cur_x), 16'd1);
        send(8'h0D);
        chk("x_after_cr", 16'(cur_x), 16'd0);
        send(8'h08);
        chk("x_bs_at0", 16'(cur_x), 16'd0);
        rd(9'd0, 10'd0);
        chk("cell_00_X", 16'(glyph_code), 16'h58);
        send(8'h41);
        send(8'h42);
        send(8'h08);
        chk("bs_x", 16'(cur_x), 16'd1);
        rd(9'd0, 10'd8);
        chk("bs_blank", 16'(glyph_code), 16'h20);
        rd(9'd0, 10'd0);
        chk("bs_keep", 16'(glyph_code), 16'h41);

        send(8'h0D);
        repeat (29) send(8'h0A);
        chk("lf_y29", 16'(cur_y), 16'd29);
        for (int i = 0; i < 79; i++) send(8'h61 + 8'(i % 26));
        chk("x79", 16'(cur_x), 16'd79);
        chk("ready_before_wrap", 16'(in_ready), 16'd1);
        in_ascii = 8'h62;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_ready(n);
        chk("clr_line_cycles", 16'(n), 16'd80);
        chk("scroll_x", 16'(cur_x), 16'd0);
        chk("scroll_y", 16'(cur_y), 16'd29);
        rd(9'd448, 10'd0);
        chk("l28_c0", 16'(glyph_code), 16'h61);
        rd(9'd455, 10'd200);
        chk("l28_c25", 16'(glyph_code), 16'h7A);
        rd(9'd448, 10'd632);
        chk("l28_c79", 16'(glyph_code), 16'h62);
        rd(9'd464, 10'd0);
        chk("l29_c0", 16'(glyph_code), 16'h20);
        rd(9'd479, 10'd8);
        chk("l29_c1", 16'(glyph_code), 16'h20);
        rd(9'd0, 10'd0);
        chk("l0_c0", 16'(glyph_code), 16'h20);

        rd(9'h1F0, 10'd0);
        chk("oor_row", 16'(glyph_code), 16'h20);
        rd(9'd432, 10'h3F0);
        chk("oor_col", 16'(glyph_code), 16'h20);
        rd(9'd448, 10'd640);
        chk("oor_col640", 16'(glyph_code), 16'h20);

        send(8'h0C);
        wait_ready(n);
        chk("ff_cycles", 16'(n), 16'd2400);
        chk("ff_x", 16'(cur_x), 16'd0);
        chk("ff_y", 16'(cur_y), 16'd0);
        rd(9'd448, 10'd0);
        chk("ff_blank", 16'(glyph_code), 16'h20);
        send(8'h5A);
        rd(9'd0, 10'd0);
        chk("ff_top0", 16'(glyph_code), 16'h5A);
        chk("z_x", 16'(cur_x), 16'd1);

`ifdef TEXT_BUFFER_CURSOR_BLINK_EN
        rd(9'd0, 10'd8);
        chk("blink_on", 16'(cursor_on), 16'd1);
        rd(9'd0, 10'd0);
        chk("blink_other", 16'(cursor_on), 16'd0);
        pulse_frame();
        pulse_frame();
        rd(9'd0, 10'd8);
        chk("blink_off", 16'(cursor_on), 16'd0);
        pulse_frame();
        pulse_frame();
        rd(9'd0, 10'd8);
        chk("blink_on2", 16'(cursor_on), 16'd1);
`else
        rd(9'd0, 10'd8);
        chk("nocur_a", 16'(cursor_on), 16'd0);
        pulse_frame();
        pulse_frame();
        rd(9'd0, 10'd8);
        chk("nocur_b", 16'(cursor_on), 16'd0);
`endif

        pix_row = 9'd0;
        pix_col = 10'd8;
        in_ascii = 8'h51;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("collide_old", 16'(glyph_code), 16'h20);
        tick();
        chk("collide_new", 16'(glyph_code), 16'h51);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
